// File: rtl/i2c_master_word_ctl.sv
// Word-level I2C master sequencer: turns START/WRITE/READ/ACK/STOP word commands into bit commands.
// Optional SMBus PEC (CRC-8) over data bits is enabled with `define I2C_WORD_PEC_EN.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready_o high when enabled
// ST_START | issuing (repeated) START
// ST_WRITE | shifting out the data word, MSB first
// ST_READ  | shifting in the data word, MSB first
// ST_ACK   | reading slave ACK (write) or sending master ACK (read)
// ST_STOP  | issuing STOP
module i2c_master_word_ctl #(
    parameter int WORD_BITS = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 sysclk_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_start_i,
    input  logic                 cmd_write_i,
    input  logic                 cmd_read_i,
    input  logic                 cmd_stop_i,
    input  logic                 ack_in_i,
    input  logic [WORD_BITS-1:0] data_i,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 done_o,
    output logic                 rx_ack_o,
    output logic                 al_o,
    output logic                 busy_o,
    output logic [2:0]           bit_cmd_o,
    output logic                 bit_din_o,
    input  logic                 bit_ack_i,
    input  logic                 bit_dout_i,
`ifdef I2C_WORD_PEC_EN
    input  logic                 pec_clr_i,
    output logic [7:0]           pec_o,
`endif
    input  logic                 bit_al_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    localparam logic [2:0] BC_NOP   = 3'd0;
    localparam logic [2:0] BC_START = 3'd1;
    localparam logic [2:0] BC_STOP  = 3'd2;
    localparam logic [2:0] BC_WRITE = 3'd3;
    localparam logic [2:0] BC_READ  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORD_BITS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic                 stop_q, stop_d;
    logic [2:0]           bit_cmd_q, bit_cmd_d;
    logic                 bit_din_q, bit_din_d;
    logic                 done_q, done_d;
    logic                 al_q, al_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic                 rx_ack_q, rx_ack_d;

    logic                 accept;
    logic                 abort;
    logic                 last_bit;
    logic                 finish;
    logic [WORD_BITS-1:0] shift_rd;

    assign cmd_ready_o = (state_q == ST_IDLE) && enable_i;
    assign busy_o      = (state_q != ST_IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;
    // Loss of arbitration or a disable both drop the transfer without a STOP.
    assign abort       = (state_q != ST_IDLE) && (!enable_i || bit_al_i);
    assign last_bit    = (cnt_q == '0);
    assign shift_rd    = (shift_q << 1) | WORD_BITS'(bit_dout_i);

    assign bit_cmd_o = bit_cmd_q;
    assign bit_din_o = bit_din_q;
    assign done_o    = done_q;
    assign al_o      = al_q;
    assign data_o    = data_q;
    assign rx_ack_o  = rx_ack_q;

`ifdef I2C_WORD_PEC_EN
    logic [7:0] pec_q, pec_d;
    logic       pec_upd;
    logic       pec_bit;
    assign pec_o = pec_q;
`endif

    always_ff @(posedge sysclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '1;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            stop_q    <= 1'b0;
            bit_cmd_q <= BC_NOP;
            bit_din_q <= 1'b1;
            done_q    <= 1'b0;
            al_q      <= 1'b0;
            data_q    <= '0;
            rx_ack_q  <= 1'b1;
`ifdef I2C_WORD_PEC_EN
            pec_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            stop_q    <= stop_d;
            bit_cmd_q <= bit_cmd_d;
            bit_din_q <= bit_din_d;
            done_q    <= done_d;
            al_q      <= al_d;
            data_q    <= data_d;
            rx_ack_q  <= rx_ack_d;
`ifdef I2C_WORD_PEC_EN
            pec_q     <= pec_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        stop_d  = stop_q;
        finish  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wr_d    = cmd_write_i;
                        rd_d    = cmd_read_i && !cmd_write_i;
                        stop_d  = cmd_stop_i;
                        shift_d = data_i;
                        cnt_d   = CNT_LOAD;
                        if (cmd_start_i)      state_d = ST_START;
                        else if (cmd_write_i) state_d = ST_WRITE;
                        else if (cmd_read_i)  state_d = ST_READ;
                        else if (cmd_stop_i)  state_d = ST_STOP;
                        else                  finish  = 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_ack_i) begin
                        if (wr_q)        state_d = ST_WRITE;
                        else if (rd_q)   state_d = ST_READ;
                        else if (stop_q) state_d = ST_STOP;
                        else begin
                            state_d = ST_IDLE;
                            finish  = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bit_ack_i) begin
                        shift_d = shift_q << 1;
                        cnt_d   = cnt_q - 1'b1;
                        if (last_bit) state_d = ST_ACK;
                    end
                end
                ST_READ: begin
                    if (bit_ack_i) begin
                        shift_d = shift_rd;
                        cnt_d   = cnt_q - 1'b1;
                        if (last_bit) state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (bit_ack_i) begin
                        if (stop_q) state_d = ST_STOP;
                        else begin
                            state_d = ST_IDLE;
                            finish  = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_ack_i) begin
                        state_d = ST_IDLE;
                        finish  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cmd_d = BC_NOP;
        bit_din_d = 1'b1;
        done_d    = finish;
        al_d      = (state_q != ST_IDLE) && bit_al_i;
        data_d    = data_q;
        rx_ack_d  = rx_ack_q;
        // A fresh bit command is presented one idle cycle after every ack.
        if (!abort && !bit_ack_i) begin
            case (state_q)
                ST_START: bit_cmd_d = BC_START;
                ST_WRITE: begin
                    bit_cmd_d = BC_WRITE;
                    bit_din_d = shift_q[WORD_BITS-1];
                end
                ST_READ:  bit_cmd_d = BC_READ;
                ST_ACK: begin
                    if (wr_q) begin
                        bit_cmd_d = BC_READ;
                    end else begin
                        bit_cmd_d = BC_WRITE;
                        bit_din_d = ack_in_i;
                    end
                end
                ST_STOP:  bit_cmd_d = BC_STOP;
                default:  bit_cmd_d = BC_NOP;
            endcase
        end
        if (!abort && bit_ack_i && state_q == ST_READ && last_bit) data_d = shift_rd;
        if (!abort && bit_ack_i && state_q == ST_ACK && wr_q)      rx_ack_d = bit_dout_i;
`ifdef I2C_WORD_PEC_EN
        pec_upd = !abort && bit_ack_i && (state_q == ST_WRITE || state_q == ST_READ);
        pec_bit = (state_q == ST_WRITE) ? shift_q[WORD_BITS-1] : bit_dout_i;
        pec_d   = pec_q;
        if (pec_clr_i)    pec_d = 8'h00;
        else if (pec_upd) pec_d = {pec_q[6:0], 1'b0} ^ ((pec_q[7] ^ pec_bit) ? 8'h07 : 8'h00);
`endif
    end

endmodule

// File: tb/tb_i2c_master_word_ctl.sv
// Scoreboard bench for i2c_master_word_ctl: a bit-controller responder drives acks,
// a monitor pops expected bit commands / done / al events and compares them.
module tb_i2c_master_word_ctl;

    localparam int K_CMD  = 0;
    localparam int K_DONE = 1;
    localparam int K_AL   = 2;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic       sysclk_i = 1'b0;
    logic       reset_n_i;
    logic       enable_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_start_i, cmd_write_i, cmd_read_i, cmd_stop_i, ack_in_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       done_o, rx_ack_o, al_o, busy_o;
    logic [2:0] bit_cmd_o;
    logic       bit_din_o;
    logic       bit_ack_i, bit_dout_i, bit_al_i;

    logic       w9_valid, w9_ready, w9_done, w9_rx_ack, w9_al, w9_busy, w9_din, w9_ack;
    logic [8:0] w9_data;
    logic [2:0] w9_cmd;

`ifdef I2C_WORD_PEC_EN
    logic       pec_clr_i;
    logic [7:0] pec_o;
    logic [7:0] w9_pec;
`endif

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    exp_t w9_q[$];
    logic rd_bits[$];
    int   al_at     = -1;
    int   ack_count = 0;

    always #5 sysclk_i = ~sysclk_i;

    i2c_master_word_ctl #(.WORD_BITS(8), .CNT_W(4)) u_dut (
        .sysclk_i    (sysclk_i),
        .reset_n_i   (reset_n_i),
        .enable_i    (enable_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_start_i (cmd_start_i),
        .cmd_write_i (cmd_write_i),
        .cmd_read_i  (cmd_read_i),
        .cmd_stop_i  (cmd_stop_i),
        .ack_in_i    (ack_in_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .done_o      (done_o),
        .rx_ack_o    (rx_ack_o),
        .al_o        (al_o),
        .busy_o      (busy_o),
        .bit_cmd_o   (bit_cmd_o),
        .bit_din_o   (bit_din_o),
        .bit_ack_i   (bit_ack_i),
        .bit_dout_i  (bit_dout_i),
`ifdef I2C_WORD_PEC_EN
        .pec_clr_i   (pec_clr_i),
        .pec_o       (pec_o),
`endif
        .bit_al_i    (bit_al_i)
    );

    i2c_master_word_ctl #(.WORD_BITS(9), .CNT_W(4)) u_w9 (
        .sysclk_i    (sysclk_i),
        .reset_n_i   (reset_n_i),
        .enable_i    (1'b1),
        .cmd_valid_i (w9_valid),
        .cmd_ready_o (w9_ready),
        .cmd_start_i (1'b0),
        .cmd_write_i (1'b1),
        .cmd_read_i  (1'b0),
        .cmd_stop_i  (1'b0),
        .ack_in_i    (1'b0),
        .data_i      (9'h1A5),
        .data_o      (w9_data),
        .done_o      (w9_done),
        .rx_ack_o    (w9_rx_ack),
        .al_o        (w9_al),
        .busy_o      (w9_busy),
        .bit_cmd_o   (w9_cmd),
        .bit_din_o   (w9_din),
        .bit_ack_i   (w9_ack),
        .bit_dout_i  (1'b0),
`ifdef I2C_WORD_PEC_EN
        .pec_clr_i   (1'b0),
        .pec_o       (w9_pec),
`endif
        .bit_al_i    (1'b0)
    );

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push_ev(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_cmd(input int cmd, input int din);
        push_ev(K_CMD, cmd * 2 + din);
    endfunction

    function automatic void exp_done(input int rx, input int data);
        push_ev(K_DONE, rx * 1024 + data);
    endfunction

    function automatic void pop_check(input string name, input int kind, input int val);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected_kind"}, kind, -1);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_kind"}, kind, e.kind);
        check({name, "_val"}, val, e.val);
    endfunction

    function automatic void w9_pop(input string name, input int kind, input int val);
        exp_t e;
        if (w9_q.size() == 0) begin
            check({name, "_unexpected_kind"}, kind, -1);
            return;
        end
        e = w9_q.pop_front();
        check({name, "_kind"}, kind, e.kind);
        check({name, "_val"}, val, e.val);
    endfunction

    // Monitor for the 8-bit instance: a bit command is sampled when it first appears.
    initial begin : monitor
        logic [2:0] prev_cmd;
        prev_cmd = 3'd0;
        forever begin
            @(negedge sysclk_i);
            if (reset_n_i) begin
                if (bit_cmd_o != 3'd0 && prev_cmd == 3'd0)
                    pop_check("bitcmd", K_CMD, int'(bit_cmd_o) * 2 + int'(bit_din_o));
                if (done_o) begin
                    pop_check("done", K_DONE, int'(rx_ack_o) * 1024 + int'(data_o));
                    check("done_ready", int'(cmd_ready_o), 1);
                    check("done_bitcmd", int'(bit_cmd_o), 0);
                end
                if (al_o) begin
                    pop_check("al", K_AL, 0);
                    check("al_ready", int'(cmd_ready_o), 1);
                    check("al_bitcmd", int'(bit_cmd_o), 0);
                end
            end
            prev_cmd = bit_cmd_o;
        end
    end

    // Bit-controller model: acks each command two cycles after it appears.
    initial begin : responder
        int wait_cnt;
        wait_cnt   = 0;
        bit_ack_i  = 1'b0;
        bit_al_i   = 1'b0;
        bit_dout_i = 1'b1;
        forever begin
            @(negedge sysclk_i);
            if (bit_ack_i) begin
                bit_ack_i = 1'b0;
                bit_al_i  = 1'b0;
                wait_cnt  = 0;
            end else if (bit_cmd_o != 3'd0) begin
                if (wait_cnt == 1) begin
                    bit_ack_i = 1'b1;
                    ack_count++;
                    bit_al_i = (ack_count == al_at);
                    if (bit_cmd_o == 3'd4 && rd_bits.size() > 0) bit_dout_i = rd_bits.pop_front();
                    else bit_dout_i = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // 9-bit instance: immediate ack responder and monitor.
    initial begin : w9_proc
        w9_ack = 1'b0;
        forever begin
            @(negedge sysclk_i);
            if (w9_ack) begin
                w9_ack = 1'b0;
            end else if (w9_cmd != 3'd0) begin
                w9_pop("w9_bitcmd", K_CMD, int'(w9_cmd) * 2 + int'(w9_din));
                w9_ack = 1'b1;
            end
            if (w9_done) w9_pop("w9_done", K_DONE, int'(w9_rx_ack) * 1024 + int'(w9_data));
            if (w9_al)   w9_pop("w9_al", K_AL, 0);
        end
    end

    task automatic issue(input logic st, input logic wr, input logic rd, input logic sp,
                         input logic ak, input logic [7:0] d);
        cmd_start_i = st;
        cmd_write_i = wr;
        cmd_read_i  = rd;
        cmd_stop_i  = sp;
        ack_in_i    = ak;
        data_i      = d;
        check("ready_before_cmd", int'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1;
        @(negedge sysclk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 400) begin
            @(negedge sysclk_i);
            n++;
        end
        check({name, "_in_time"}, int'(n >= 400), 0);
        repeat (4) @(negedge sysclk_i);
    endtask

    initial begin : stim
        logic [7:0] d;
        logic [8:0] d9;
        logic [7:0] rd_pat;
        int n;
        reset_n_i   = 1'b0;
        enable_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_start_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_read_i  = 1'b0;
        cmd_stop_i  = 1'b0;
        ack_in_i    = 1'b0;
        data_i      = 8'h00;
        w9_valid    = 1'b0;
`ifdef I2C_WORD_PEC_EN
        pec_clr_i   = 1'b0;
`endif
        repeat (3) @(negedge sysclk_i);
        check("rst_ready",   int'(cmd_ready_o), 1);
        check("rst_done",    int'(done_o), 0);
        check("rst_al",      int'(al_o), 0);
        check("rst_busy",    int'(busy_o), 0);
        check("rst_rx_ack",  int'(rx_ack_o), 1);
        check("rst_bit_cmd", int'(bit_cmd_o), 0);
        check("rst_bit_din", int'(bit_din_o), 1);
        check("rst_data",    int'(data_o), 0);
`ifdef I2C_WORD_PEC_EN
        check("rst_pec",     int'(pec_o), 0);
`endif
        reset_n_i = 1'b1;
        @(negedge sysclk_i);

        // start + write 0xA5, slave ACKs
`ifdef I2C_WORD_PEC_EN
        pec_clr_i = 1'b1;
        @(negedge sysclk_i);
        pec_clr_i = 1'b0;
`endif
        d = 8'hA5;
        exp_cmd(1, 1);
        for (int i = 7; i >= 0; i--) exp_cmd(3, int'(d[i]));
        exp_cmd(4, 1);
        exp_done(0, 8'h00);
        rd_bits.push_back(1'b0);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d);
        wait_idle("t1");
`ifdef I2C_WORD_PEC_EN
        check("pec_a5", int'(pec_o), 8'h72);
`endif

        // read + stop with master NACK
        rd_pat = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            rd_bits.push_back(rd_pat[i]);
            exp_cmd(4, 1);
        end
        exp_cmd(3, 1);
        exp_cmd(2, 1);
        exp_done(0, 8'h3C);
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        wait_idle("t2");
`ifdef I2C_WORD_PEC_EN
        pec_clr_i = 1'b1;
        @(negedge sysclk_i);
        pec_clr_i = 1'b0;
        @(negedge sysclk_i);
        check("pec_clear", int'(pec_o), 0);
`endif

        // write 0xFF, arbitration lost on the 3rd bit ack
        ack_count = 0;
        al_at     = 3;
        for (int i = 0; i < 3; i++) exp_cmd(3, 1);
        push_ev(K_AL, 0);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        wait_idle("t3");
        al_at = -1;
        check("al_keeps_data", int'(data_o), 8'h3C);

        // no flags: done one cycle after acceptance, no bus activity
        exp_done(0, 8'h3C);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("noflag_done_latency", int'(done_o), 1);
        wait_idle("t4a");

        // disable during a read
        ack_count = 0;
        for (int i = 0; i < 8; i++) rd_bits.push_back(1'b1);
        for (int i = 0; i < 3; i++) exp_cmd(4, 1);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (ack_count < 3 && n < 200) begin
            @(negedge sysclk_i);
            n++;
        end
        check("t4b_acks_in_time", int'(n >= 200), 0);
        enable_i = 1'b0;
        repeat (3) @(negedge sysclk_i);
        check("dis_busy",    int'(busy_o), 0);
        check("dis_ready",   int'(cmd_ready_o), 0);
        check("dis_bit_cmd", int'(bit_cmd_o), 0);
        check("dis_data",    int'(data_o), 8'h3C);
        enable_i = 1'b1;
        wait_idle("t4b");
        rd_bits.delete();

        // 9-bit word: nine WRITE bits then the ACK READ
        d9 = 9'h1A5;
        for (int i = 8; i >= 0; i--) begin
            exp_t e;
            e.kind = K_CMD;
            e.val  = 3 * 2 + int'(d9[i]);
            w9_q.push_back(e);
        end
        begin
            exp_t e;
            e.kind = K_CMD;
            e.val  = 4 * 2 + 1;
            w9_q.push_back(e);
            e.kind = K_DONE;
            e.val  = 0;
            w9_q.push_back(e);
        end
        check("w9_ready", int'(w9_ready), 1);
        w9_valid = 1'b1;
        @(negedge sysclk_i);
        w9_valid = 1'b0;
        n = 0;
        while ((w9_q.size() != 0 || w9_busy) && n < 400) begin
            @(negedge sysclk_i);
            n++;
        end
        check("w9_in_time", int'(n >= 400), 0);
`ifdef I2C_WORD_PEC_EN
        check("w9_pec", int'(w9_pec), 8'h67);
`endif

        repeat (5) @(negedge sysclk_i);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
